// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : alu_pkg                                                           |
// | Brief  : Shared opcodes, flag indices, FSM encoding for the ALU issue stage |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
package alu_pkg;

    localparam int c_flag_w = 6;

    localparam logic [4:0] INC = 5'b00001;
    localparam logic [4:0] DEC = 5'b00011;
    localparam logic [4:0] ADD = 5'b00100;
    localparam logic [4:0] ADC = 5'b00101;
    localparam logic [4:0] SUB = 5'b00110;
    localparam logic [4:0] SBB = 5'b00111;
    localparam logic [4:0] AND = 5'b01000;
    localparam logic [4:0] OR  = 5'b01001;
    localparam logic [4:0] XOR = 5'b01010;
    localparam logic [4:0] NOT = 5'b01011;
    localparam logic [4:0] SHL = 5'b10000;
    localparam logic [4:0] SHR = 5'b10001;
    localparam logic [4:0] SAL = 5'b10010;
    localparam logic [4:0] SAR = 5'b10011;
    localparam logic [4:0] ROL = 5'b10100;
    localparam logic [4:0] ROR = 5'b10101;
    localparam logic [4:0] RCL = 5'b10110;
    localparam logic [4:0] RCR = 5'b10111;

    localparam int CARRY_F     = 5;
    localparam int ZERO_F      = 4;
    localparam int NEG_F       = 3;
    localparam int OVF_F       = 2;
    localparam int PARITY_F    = 1;
    localparam int AUX_CARRY_F = 0;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_exec = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    // Valid codes: INC, DEC, the arithmetic block, the logic block, all shifts/rotates.
    function automatic logic is_valid_f(input logic [4:0] f);
        return (f == INC) || (f == DEC) ||
               (f[4:2] == 3'b001) || (f[4:2] == 3'b010) || (f[4:3] == 2'b10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : alu_issue_ctrl_if                                                 |
// | Brief  : Command, ALU and response bundles of the ALU issue stage          |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface alu_issue_ctrl_if #(
    parameter int DW = 16,
    parameter int AW = 3
) ();
    logic          cmd_valid;
    logic          cmd_ready;
    logic [4:0]    cmd_f;
    logic [AW-1:0] cmd_rd;
    logic [AW-1:0] cmd_rs;
    logic          cmd_imm_en;
    logic [DW-1:0] cmd_imm;

    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [4:0]    alu_f;
    logic          alu_cin;
    logic [DW-1:0] alu_result;
    logic [5:0]    alu_status;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_result;
    logic [5:0]    rsp_flags;
    logic          rsp_err;

    modport slave (
        input  cmd_valid, cmd_f, cmd_rd, cmd_rs, cmd_imm_en, cmd_imm,
        output cmd_ready,
        output alu_a, alu_b, alu_f, alu_cin,
        input  alu_result, alu_status,
        output rsp_valid, rsp_result, rsp_flags, rsp_err,
        input  rsp_ready
    );

    modport master (
        output cmd_valid, cmd_f, cmd_rd, cmd_rs, cmd_imm_en, cmd_imm,
        input  cmd_ready,
        input  alu_a, alu_b, alu_f, alu_cin,
        output alu_result, alu_status,
        input  rsp_valid, rsp_result, rsp_flags, rsp_err,
        output rsp_ready
    );
endinterface
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : alu_regfile                                                       |
// | Brief  : NREGS x DW register file, 2 comb read ports + debug read, 1 write |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module alu_regfile #(
    parameter int NREGS = 8,
    parameter int DW    = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic [AW-1:0] i_rd_addr_a,
    output logic      [DW-1:0] o_rd_data_a,
    input  wire logic [AW-1:0] i_rd_addr_b,
    output logic      [DW-1:0] o_rd_data_b,
    input  wire logic [AW-1:0] i_dbg_addr,
    output logic      [DW-1:0] o_dbg_data,
    input  wire logic          i_wr_en,
    input  wire logic [AW-1:0] i_wr_addr,
    input  wire logic [DW-1:0] i_wr_data
);
    logic [DW-1:0] r_regs [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data_a = r_regs[i_rd_addr_a];
    assign o_rd_data_b = r_regs[i_rd_addr_b];
    assign o_dbg_data  = r_regs[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : alu_issue_ctrl                                                    |
// | Brief  : Issue/writeback stage around a combinational 16-bit ALU           |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int DW    = 16
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    alu_issue_ctrl_if.slave                 bus,
    output logic      [c_flag_w-1:0]        flags,
    input  wire logic [$clog2(NREGS)-1:0]   dbg_addr,
    output logic      [DW-1:0]              dbg_data
);
    localparam int AW = $clog2(NREGS);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [4:0]          r_f;
    logic [AW-1:0]       r_rd;
    logic [DW-1:0]       r_op_a;
    logic [DW-1:0]       r_op_b;
    logic [c_flag_w-1:0] r_flags;
    logic [DW-1:0]       r_rsp_result;
    logic [c_flag_w-1:0] r_rsp_flags;
    logic                r_rsp_err;

    logic [DW-1:0]       w_rd_a;
    logic [DW-1:0]       w_rd_b;
    logic                w_accept;
    logic                w_f_valid;
    logic                w_wr_en;

    // Operands are read at acceptance from the command fields, so the
    // register file needs no separate read-enable timing.
    alu_regfile #(
        .NREGS (NREGS),
        .DW    (DW),
        .AW    (AW)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .i_rd_addr_a (bus.cmd_rd),
        .o_rd_data_a (w_rd_a),
        .i_rd_addr_b (bus.cmd_rs),
        .o_rd_data_b (w_rd_b),
        .i_dbg_addr  (dbg_addr),
        .o_dbg_data  (dbg_data),
        .i_wr_en     (w_wr_en),
        .i_wr_addr   (r_rd),
        .i_wr_data   (bus.alu_result)
    );

    assign w_accept  = (r_state == c_st_idle) && bus.cmd_valid;
    assign w_f_valid = is_valid_f(r_f);
    assign w_wr_en   = (r_state == c_st_exec) && w_f_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: if (bus.cmd_valid) w_next_state = c_st_exec;
            c_st_exec: w_next_state = c_st_resp;
            c_st_resp: if (bus.rsp_ready) w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_f          <= '0;
            r_rd         <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_flags      <= '0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_f    <= bus.cmd_f;
                r_rd   <= bus.cmd_rd;
                r_op_a <= w_rd_a;
                r_op_b <= bus.cmd_imm_en ? bus.cmd_imm : w_rd_b;
            end
            if (r_state == c_st_exec) begin
                // Unsupported codes leave architectural state untouched.
                if (w_f_valid) begin
                    r_flags      <= bus.alu_status;
                    r_rsp_result <= bus.alu_result;
                    r_rsp_flags  <= bus.alu_status;
                    r_rsp_err    <= 1'b0;
                end else begin
                    r_rsp_result <= '0;
                    r_rsp_flags  <= r_flags;
                    r_rsp_err    <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.cmd_ready  = (r_state == c_st_idle);
        bus.rsp_valid  = (r_state == c_st_resp);
        bus.alu_a      = '0;
        bus.alu_b      = '0;
        bus.alu_f      = '0;
        bus.alu_cin    = 1'b0;
        if (r_state == c_st_exec) begin
            bus.alu_a   = r_op_a;
            bus.alu_b   = r_op_b;
            bus.alu_f   = r_f;
            bus.alu_cin = r_flags[CARRY_F];
        end
    end

    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_flags  = r_rsp_flags;
    assign bus.rsp_err    = r_rsp_err;
    assign flags          = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_alu_issue_ctrl                                                 |
// | Brief  : Self-checking bench: directed table, stall/reset corners, random  |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  flags;
    logic [2:0]  dbg_addr = 3'd0;
    logic [15:0] dbg_data;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] ref_regs [8];
    logic [5:0]  ref_flags;
    logic [4:0]  valid_codes [$];

    typedef struct {
        logic [4:0]  f;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic        imm_en;
        logic [15:0] imm;
        logic [15:0] exp_res;
        logic [5:0]  exp_flags;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];

    alu_issue_ctrl_if #(.DW(16), .AW(3)) bus ();

    alu_issue_ctrl #(.NREGS(8), .DW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .flags    (flags),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {C,Z,N,O,P,AC, result}.
    function automatic logic [21:0] alu_model(input logic [4:0] f, input logic [15:0] a,
                                              input logic [15:0] b, input logic cin);
        logic [16:0] w;
        logic [4:0]  nib;
        logic [15:0] r;
        logic        c, o, ac, ci;
        c = 1'b0; o = 1'b0; ac = 1'b0; r = 16'hDEAD;
        ci = (f == 5'b00101 || f == 5'b00111) ? cin : 1'b0;
        case (f)
            5'b00001: begin
                r = a + 16'd1; c = (a == 16'hFFFF); ac = (a[3:0] == 4'hF); o = (a == 16'h7FFF);
            end
            5'b00011: begin
                r = a - 16'd1; c = (a == 16'h0000); ac = (a[3:0] == 4'h0); o = (a == 16'h8000);
            end
            5'b00100, 5'b00101: begin
                w = {1'b0, a} + {1'b0, b} + {16'b0, ci};
                nib = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, ci};
                r = w[15:0]; c = w[16]; ac = nib[4];
                o = (a[15] == b[15]) && (r[15] != a[15]);
            end
            5'b00110, 5'b00111: begin
                w = {1'b0, a} - {1'b0, b} - {16'b0, ci};
                nib = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, ci};
                r = w[15:0]; c = w[16]; ac = nib[4];
                o = (a[15] != b[15]) && (r[15] != a[15]);
            end
            5'b01000: r = a & b;
            5'b01001: r = a | b;
            5'b01010: r = a ^ b;
            5'b01011: r = ~a;
            5'b10000, 5'b10010: begin r = {a[14:0], 1'b0}; c = a[15]; end
            5'b10001: begin r = {1'b0, a[15:1]}; c = a[0]; end
            5'b10011: begin r = {a[15], a[15:1]}; c = a[0]; end
            5'b10100: begin r = {a[14:0], a[15]}; c = a[15]; end
            5'b10101: begin r = {a[0], a[15:1]}; c = a[0]; end
            5'b10110: begin r = {a[14:0], cin}; c = a[15]; end
            5'b10111: begin r = {cin, a[15:1]}; c = a[0]; end
            default: r = 16'hDEAD;
        endcase
        return {c, (r == 16'h0000), r[15], o, ~^r[7:0], ac, r};
    endfunction

    function automatic logic ref_valid_f(input logic [4:0] f);
        return f inside {5'b00001, 5'b00011, [5'b00100:5'b00111],
                         [5'b01000:5'b01011], [5'b10000:5'b10111]};
    endfunction

    logic [21:0] alu_out;
    assign alu_out        = alu_model(bus.alu_f, bus.alu_a, bus.alu_b, bus.alu_cin);
    assign bus.alu_result = alu_out[15:0];
    assign bus.alu_status = alu_out[21:16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 8; i++) ref_regs[i] = 16'h0000;
        ref_flags = 6'b000000;
    endtask

    task automatic run_cmd(input logic [4:0] f, input logic [2:0] rd, input logic [2:0] rs,
                           input logic imm_en, input logic [15:0] imm, input int stall,
                           input bit poke, output logic [15:0] got_res,
                           output logic [5:0] got_flags, output logic got_err);
        logic [15:0] ea, eb, eres;
        logic [5:0]  eflags;
        logic        eerr, ecin;
        logic [21:0] m;
        ea   = ref_regs[rd];
        eb   = imm_en ? imm : ref_regs[rs];
        ecin = ref_flags[5];
        @(negedge clk);
        check("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_f = f; bus.cmd_rd = rd; bus.cmd_rs = rs;
        bus.cmd_imm_en = imm_en; bus.cmd_imm = imm; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("exec_alu_a", bus.alu_a, ea);
        check("exec_alu_b", bus.alu_b, eb);
        check("exec_alu_f", bus.alu_f, f);
        check("exec_alu_cin", bus.alu_cin, ecin);
        check("exec_cmd_ready", bus.cmd_ready, 0);
        check("exec_rsp_valid", bus.rsp_valid, 0);
        if (ref_valid_f(f)) begin
            m = alu_model(f, ea, eb, ecin);
            eres = m[15:0]; eflags = m[21:16]; eerr = 1'b0;
            ref_regs[rd] = eres; ref_flags = eflags;
        end else begin
            eres = 16'h0000; eflags = ref_flags; eerr = 1'b1;
        end
        @(negedge clk);
        check("rsp_valid_k1", bus.rsp_valid, 1);
        check("rsp_result", bus.rsp_result, eres);
        check("rsp_flags", bus.rsp_flags, eflags);
        check("rsp_err", bus.rsp_err, eerr);
        check("flags_reg", flags, ref_flags);
        dbg_addr = rd;
        #1;
        check("dbg_rd", dbg_data, ref_regs[rd]);
        got_res = bus.rsp_result; got_flags = bus.rsp_flags; got_err = bus.rsp_err;
        for (int s = 0; s < stall; s++) begin
            if (poke) begin
                bus.cmd_f = 5'b00100; bus.cmd_rd = rd + 3'd1; bus.cmd_imm_en = 1'b1;
                bus.cmd_imm = 16'hFFFF; bus.cmd_valid = 1'b1;
            end
            @(negedge clk);
            check("stall_rsp_valid", bus.rsp_valid, 1);
            check("stall_rsp_result", bus.rsp_result, got_res);
            check("stall_rsp_flags", bus.rsp_flags, got_flags);
            check("stall_cmd_ready", bus.cmd_ready, 0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("post_hs_rsp_valid", bus.rsp_valid, 0);
        check("post_hs_cmd_ready", bus.cmd_ready, 1);
        if (poke) begin
            dbg_addr = rd + 3'd1;
            #1;
            check("ignored_cmd_reg", dbg_data, ref_regs[rd + 3'd1]);
            check("ignored_cmd_flags", flags, ref_flags);
        end
    endtask

    initial begin
        logic [15:0] res;
        logic [5:0]  fl;
        logic        err;
        logic [4:0]  rf;

        vecs[0] = '{5'b01001, 3'd1, 3'd0, 1'b1, 16'h0003, 16'h0003, 6'b000010, 1'b0};
        vecs[1] = '{5'b00100, 3'd2, 3'd1, 1'b0, 16'h0000, 16'h0003, 6'b000010, 1'b0};
        vecs[2] = '{5'b00100, 3'd2, 3'd0, 1'b1, 16'h0004, 16'h0007, 6'b000000, 1'b0};
        vecs[3] = '{5'b01001, 3'd3, 3'd0, 1'b1, 16'hFFFF, 16'hFFFF, 6'b001010, 1'b0};
        vecs[4] = '{5'b00100, 3'd3, 3'd0, 1'b1, 16'h0001, 16'h0000, 6'b110011, 1'b0};
        vecs[5] = '{5'b00101, 3'd4, 3'd0, 1'b1, 16'h0000, 16'h0001, 6'b000000, 1'b0};
        vecs[6] = '{5'b00000, 3'd4, 3'd0, 1'b1, 16'h0005, 16'h0000, 6'b000000, 1'b1};
        vecs[7] = '{5'b01010, 3'd2, 3'd2, 1'b0, 16'h0000, 16'h0000, 6'b010010, 1'b0};
        vecs[8] = '{5'b11111, 3'd2, 3'd3, 1'b0, 16'h0000, 16'h0000, 6'b010010, 1'b1};

        for (int i = 0; i < 32; i++) begin
            if (ref_valid_f(5'(i))) valid_codes.push_back(5'(i));
        end

        bus.cmd_valid = 1'b0; bus.cmd_f = '0; bus.cmd_rd = '0; bus.cmd_rs = '0;
        bus.cmd_imm_en = 1'b0; bus.cmd_imm = '0; bus.rsp_ready = 1'b0;
        reset_model();

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_cmd_ready", bus.cmd_ready, 1);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_rsp_result", bus.rsp_result, 0);
        check("reset_rsp_flags", bus.rsp_flags, 0);
        check("reset_rsp_err", bus.rsp_err, 0);
        check("reset_alu_a", bus.alu_a, 0);
        check("reset_alu_cin", bus.alu_cin, 0);
        check("reset_flags", flags, 0);

        for (int i = 0; i < 9; i++) begin
            run_cmd(vecs[i].f, vecs[i].rd, vecs[i].rs, vecs[i].imm_en, vecs[i].imm,
                    0, 1'b0, res, fl, err);
            check("vec_result", res, vecs[i].exp_res);
            check("vec_flags", fl, vecs[i].exp_flags);
            check("vec_err", err, vecs[i].exp_err);
        end

        // Backpressure: response held for five cycles while a stray command is offered.
        run_cmd(5'b00100, 3'd6, 3'd3, 1'b1, 16'h1111, 5, 1'b1, res, fl, err);
        check("stall_vec_result", res, 16'h1111);

        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) rf = 5'($urandom_range(0, 31));
            else rf = valid_codes[$urandom_range(0, valid_codes.size() - 1)];
            run_cmd(rf, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 16'($urandom), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), res, fl, err);
        end

        // Reset while EXEC is in flight: the write must not land.
        @(negedge clk);
        bus.cmd_f = 5'b00100; bus.cmd_rd = 3'd5; bus.cmd_imm_en = 1'b1;
        bus.cmd_imm = 16'h1234; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("pre_rst_exec_alu_b", bus.alu_b, 16'h1234);
        rst = 1'b1;
        #1;
        check("rst_async_cmd_ready", bus.cmd_ready, 1);
        check("rst_async_rsp_valid", bus.rsp_valid, 0);
        check("rst_async_alu_b", bus.alu_b, 0);
        check("rst_async_flags", flags, 0);
        @(negedge clk);
        rst = 1'b0;
        reset_model();
        @(negedge clk);
        check("post_rst_cmd_ready", bus.cmd_ready, 1);
        check("post_rst_rsp_valid", bus.rsp_valid, 0);
        check("post_rst_flags", flags, 0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check("post_rst_reg", dbg_data, 0);
        end

        run_cmd(5'b01001, 3'd1, 3'd0, 1'b1, 16'h0003, 0, 1'b0, res, fl, err);
        check("post_rst_or_result", res, 16'h0003);
        check("post_rst_or_flags", fl, 6'b000010);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
